// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op encodings, FSM states and width default for the divider
package div_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
// Ports:
//   rem_in   partial remainder before this step
//   dbit     next dividend bit shifted into the remainder
//   divisor  divisor magnitude
//   rem_out  partial remainder after this step
//   qbit     quotient bit produced by this step
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dbit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            qbit
);

    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;

    assign trial = {rem_in, dbit};
    // Extra top bit of diff is the borrow of the XLEN+1-bit trial subtract.
    assign diff  = {1'b0, trial} - {2'b00, divisor};

    // A successful subtract leaves a value below the divisor, so diff[XLEN]
    // is zero whenever the borrow is clear; folding it in changes nothing.
    assign qbit    = ~(diff[XLEN+1] | diff[XLEN]);
    assign rem_out = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring integer divider (DIV/DIVU/REM/REMU)
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op           request and operation, sampled in IDLE or DONE
//   dividend, divisor   operands, latched with start
//   kill                flush; aborts any operation, wins over start
//   result              registered quotient or remainder
//   busy                high while iterating or fixing signs
//   done                one-cycle completion pulse, result valid with it
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state, state_n;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;      // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic            q_neg;
    logic            r_neg;
    logic            rem_sel;

    logic            accept;
    logic            is_signed;
    logic            is_rem;
    logic            neg_a;
    logic            neg_b;
    logic            div0;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] fix_val;

    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign is_rem    = (op == OP_REM) || (op == OP_REMU);
    assign neg_a     = is_signed & dividend[XLEN-1];
    assign neg_b     = is_signed & divisor[XLEN-1];
    assign div0      = (divisor == '0);
    assign ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign special   = div0 | ovf;

    always_comb begin
        special_val = '0;
        if (div0) begin
            special_val = is_rem ? dividend : '1;
        end else begin
            special_val = is_rem ? '0 : dividend;
        end
    end

    assign fix_val = rem_sel ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .dbit    (quo[XLEN-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .qbit    (step_q)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        busy    = (state == RUN) || (state == FIX);
        done    = (state == DONE);
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_n = special ? DONE : RUN;
                end
            end
            RUN:     state_n = (cnt == LAST) ? FIX : RUN;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (kill) begin
            accept  = 1'b0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            rem_sel <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt     <= '0;
                quo     <= neg_a ? -dividend : dividend;
                rem     <= '0;
                dvs     <= neg_b ? -divisor : divisor;
                q_neg   <= neg_a ^ neg_b;
                r_neg   <= neg_a;
                rem_sel <= is_rem;
                if (special) begin
                    result <= special_val;
                end
            end else if (!kill) begin
                if (state == RUN) begin
                    quo <= {quo[XLEN-2:0], step_q};
                    rem <= step_rem;
                    cnt <= cnt + CW'(1);
                end else if (state == FIX) begin
                    result <= fix_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        kill;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] res;
    int          lat;
    logic        busy_seen;
    int          done_cnt;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one request, returns at the negedge where
    // done is high. lat counts rising edges from the sampling edge to the
    // first edge that sees done. poke>0 pulses a spurious start at that count.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [31:0] r, output int l,
                          output logic bs);
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        l = 1;
        bs = 1'b0;
        while (!done && l < 200) begin
            bs = bs | busy;
            start = (poke != 0) && (l == poke);
            if (start) begin
                op = OP_DIVU;
                dividend = 32'd1;
                divisor = 32'd1;
            end
            @(negedge clk);
            l++;
        end
        start = 1'b0;
        if (!done) check_eq("done_timeout", {31'd0, done}, 32'd1);
        r = result;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        op = 2'b00;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);

        // first start on first edge out of reset
        rst_n = 1'b1;
        run_op(OP_DIVU, 32'd100, 32'd7, 0, res, lat, busy_seen);
        check_eq("divu_100_7", res, 32'd14);
        check_eq("divu_100_7_lat", 32'(lat), 32'd34);

        // back-to-back from DONE
        run_op(OP_REMU, 32'd100, 32'd7, 0, res, lat, busy_seen);
        check_eq("remu_100_7", res, 32'd2);
        check_eq("b2b_lat", 32'(lat), 32'd34);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, res, lat, busy_seen);
        check_eq("div_m7_2", res, 32'hFFFF_FFFD);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 0, res, lat, busy_seen);
        check_eq("rem_m7_2", res, 32'hFFFF_FFFF);
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 0, res, lat, busy_seen);
        check_eq("rem_7_m2", res, 32'd1);
        run_op(OP_DIV, 32'h8000_0000, 32'd2, 0, res, lat, busy_seen);
        check_eq("div_min_2", res, 32'hC000_0000);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, res, lat, busy_seen);
        check_eq("divu_max_1", res, 32'hFFFF_FFFF);

        // divide by zero
        run_op(OP_DIVU, 32'd5, 32'd0, 0, res, lat, busy_seen);
        check_eq("divu_5_0", res, 32'hFFFF_FFFF);
        check_eq("divu_5_0_lat", 32'(lat), 32'd1);
        check_eq("divu_5_0_busy", {31'd0, busy_seen}, 32'd0);
        run_op(OP_REMU, 32'd5, 32'd0, 0, res, lat, busy_seen);
        check_eq("remu_5_0", res, 32'd5);
        check_eq("remu_5_0_lat", 32'(lat), 32'd1);
        check_eq("remu_5_0_busy", {31'd0, busy_seen}, 32'd0);

        // signed overflow
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, busy_seen);
        check_eq("div_ovf", res, 32'h8000_0000);
        check_eq("div_ovf_lat", 32'(lat), 32'd1);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, busy_seen);
        check_eq("rem_ovf", res, 32'd0);
        check_eq("rem_ovf_lat", 32'(lat), 32'd1);

        // kill at RUN cycle 10
        run_op(OP_DIVU, 32'd100, 32'd7, 0, res, lat, busy_seen);
        check_eq("pre_kill", res, 32'd14);
        @(negedge clk);
        op = OP_DIVU;
        dividend = 32'd1000;
        divisor = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("kill_busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_eq("kill_busy_after", {31'd0, busy}, 32'd0);
        check_eq("kill_result", result, 32'd14);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("kill_no_done", 32'(done_cnt), 32'd0);
        run_op(OP_DIVU, 32'd9, 32'd3, 0, res, lat, busy_seen);
        check_eq("divu_9_3", res, 32'd3);

        // kill and start together: request dropped
        @(negedge clk);
        op = OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd1;
        start = 1'b1;
        kill = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill = 1'b0;
        check_eq("kill_start_busy", {31'd0, busy}, 32'd0);
        check_eq("kill_start_done", {31'd0, done}, 32'd0);
        check_eq("kill_start_result", result, 32'd3);

        // start while busy is ignored
        run_op(OP_DIVU, 32'd100, 32'd7, 5, res, lat, busy_seen);
        check_eq("busy_start_result", res, 32'd14);
        check_eq("busy_start_lat", 32'(lat), 32'd34);
        check_eq("busy_start_busy", {31'd0, busy_seen}, 32'd1);

        // reset mid-RUN
        @(negedge clk);
        op = OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        run_op(OP_DIVU, 32'd9, 32'd3, 0, res, lat, busy_seen);
        check_eq("post_rst_divu", res, 32'd3);
        check_eq("post_rst_lat", 32'(lat), 32'd34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request a division; sampled only when the unit accepts requests (IDLE or DONE).
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; latched with start.
REQ-006 dividend  input  XLEN  rs1 operand; latched with start.
REQ-007 divisor  input  XLEN  rs2 operand; latched with start.
REQ-008 kill  input  1  pipeline flush; aborts any operation in progress.
REQ-009 result  output  XLEN  quotient or remainder per latched op; registered.
REQ-010 busy  output  1  high in RUN and FIX; the pipeline stalls while high.
REQ-011 done  output  1  one-cycle pulse; result is valid in the same cycle.

Function
REQ-012 FSM states: IDLE, RUN, FIX, DONE.
REQ-013 IDLE or DONE with start=1 and kill=0: latch op and operands, then go to RUN with iteration counter 0, or go to DONE directly if a special case applies (REQ-017, REQ-018).
REQ-014 RUN: perform one restoring shift-subtract step per cycle on the operand magnitudes, using an XLEN+1-bit trial subtract; after XLEN steps, go to FIX.
REQ-015 FIX: apply signs and select quotient or remainder into result, then go to DONE.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted (back-to-back allowed).
REQ-017 Divisor zero: quotient = all ones, remainder = dividend, for both signed and unsigned; done one cycle after start.
REQ-018 Signed overflow (DIV/REM, dividend = 2^(XLEN-1) negated form 0x80..0, divisor = all ones): quotient = dividend, remainder = 0; done one cycle after start.
REQ-019 Signed ops: magnitudes are taken at latch; quotient is negated if operand signs differ; remainder takes the dividend's sign. Quotient rounds toward zero.
REQ-020 Normal latency: done is high exactly XLEN+2 rising edges after the edge that sampled start.
REQ-021 start while busy=1 is ignored; no queuing.
REQ-022 kill=1 in any state: go to IDLE on the next edge; done is not asserted; result keeps its prior value.
REQ-023 kill and start in the same cycle: kill wins and the request is dropped.
REQ-024 result holds its last value until the next completion; it changes only on entry to DONE.

Reset
REQ-025 When rst_n=0 at an edge: state=IDLE, result=0, busy=0, done=0, counter=0, and all latched operands cleared. This also applies when reset is asserted mid-RUN or mid-FIX.
REQ-026 The first start is honored on the first edge with rst_n=1.

Structure
REQ-027 A shared package holds the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), the FSM state encoding, and the XLEN default.
REQ-028 One sub-module, div_step: combinational single restoring iteration, partial remainder plus dividend bit plus divisor in, next remainder plus quotient bit out; instantiated once.
REQ-029 The iteration counter is ceil(log2(XLEN+1)) bits.

Verification
REQ-030 DIVU 100/7 -> result=14, done at edge 34 after start; REMU 100/7 -> result=2.
REQ-031 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/0xFFFFFFFE (7/-2) -> 1.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done one cycle after start; busy never high.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; done one cycle after start.
REQ-034 kill at RUN cycle 10 -> IDLE next edge, no done pulse, result unchanged; a following DIVU 9/3 -> 3.
REQ-035 start pulsed while busy -> ignored, first result correct; rst_n=0 mid-RUN -> all outputs 0 next edge; back-to-back start in DONE -> second result correct with latency XLEN+2.
